// File: rtl/imm_operand_stage.sv
// Immediate extraction/extension stage feeding the EX operand mux through a 2-entry skid buffer.
// Latency 1 cycle; in_ready depends only on registered skid occupancy, so out_ready never reaches it combinationally.
module imm_operand_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_use_imm,
    output logic [4:0]        out_rt,
    output logic [DATA_W-1:0] out_pc
);
    localparam int EXT_W = DATA_W - IMM_W;

    typedef struct packed {
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic [4:0]        rt;
        logic [DATA_W-1:0] pc;
    } ent_t;

    ent_t main_q, main_d, skid_q, skid_d, in_ent;
    logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic accept, drain;

    logic [5:0]        op;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] sext, zext;
    logic              unused_ok;

    assign op        = in_instr[31:26];
    assign imm       = in_instr[IMM_W-1:0];
    assign sext      = {{EXT_W{imm[IMM_W-1]}}, imm};
    assign zext      = {{EXT_W{1'b0}}, imm};
    assign unused_ok = ^in_instr[25:21];

    always_comb begin
        in_ent         = '0;
        in_ent.rt      = in_instr[20:16];
        in_ent.pc      = in_pc;
        unique case (op)
            6'h0C, 6'h0D, 6'h0E: begin
                in_ent.imm     = zext;
                in_ent.use_imm = 1'b1;
            end
            6'h0F: begin
                in_ent.imm     = zext << EXT_W;
                in_ent.use_imm = 1'b1;
            end
            // Branch offsets are word counts; EX wants a byte offset.
            6'h04, 6'h05: begin
                in_ent.imm     = sext << 2;
                in_ent.use_imm = 1'b0;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
                in_ent.imm     = sext;
                in_ent.use_imm = 1'b1;
            end
            default: begin
                in_ent.imm     = '0;
                in_ent.use_imm = 1'b0;
            end
        endcase
    end

    assign in_ready = !skid_valid_q && !rst;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so only the skid-to-main move can happen.
            if (drain) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q && !drain) begin
            if (accept) begin
                skid_d       = in_ent;
                skid_valid_d = 1'b1;
            end
        end else begin
            main_valid_d = accept;
            if (accept) begin
                main_d = in_ent;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_q.imm;
    assign out_use_imm = main_q.use_imm;
    assign out_rt      = main_q.rt;
    assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_imm_operand_stage.sv
// Directed-vector bench for imm_operand_stage with hand-computed expected values.
module tb_imm_operand_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic [4:0]  out_rt;
    logic [31:0] out_pc;

    int test_cnt = 0;
    int fail_cnt = 0;

    imm_operand_stage #(.DATA_W(32), .IMM_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_use_imm(out_use_imm), .out_rt(out_rt), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        test_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd0, rt, imm};
    endfunction

    task automatic offer(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = mk(op, rt, imm);
        in_pc    = pc;
    endtask

    logic [5:0]  v_op  [8] = '{6'h08, 6'h0D, 6'h0F, 6'h04, 6'h00, 6'h0C, 6'h05, 6'h23};
    logic [15:0] v_imm [8] = '{16'hFFFC, 16'h8001, 16'h1234, 16'hFFFF, 16'h1234, 16'hF0F0, 16'h0010, 16'h8000};
    logic [31:0] v_exp [8] = '{32'hFFFF_FFFC, 32'h0000_8001, 32'h1234_0000, 32'hFFFF_FFFC,
                               32'h0000_0000, 32'h0000_F0F0, 32'h0000_0040, 32'hFFFF_8000};
    logic        v_use [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single ADDI, latency one.
        offer(6'h08, 5'd7, 16'hFFFC, 32'h0000_0040);
        step();
        in_valid = 1'b0;
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_imm", 64'(out_imm), 64'hFFFF_FFFC);
        check("addi_use", 64'(out_use_imm), 64'd1);
        check("addi_rt", 64'(out_rt), 64'd7);
        check("addi_pc", 64'(out_pc), 64'h40);
        step();
        check("addi_drained", 64'(out_valid), 64'd0);

        // Back-to-back stream of 8 words, one per cycle.
        for (int i = 0; i < 8; i++) begin
            offer(v_op[i], 5'(i + 1), v_imm[i], 32'h100 + 32'(i * 4));
            step();
            check($sformatf("strm%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("strm%0d_imm", i), 64'(out_imm), 64'(v_exp[i]));
            check($sformatf("strm%0d_use", i), 64'(out_use_imm), 64'(v_use[i]));
            check($sformatf("strm%0d_pc", i), 64'(out_pc), 64'h100 + 64'(i * 4));
            check($sformatf("strm%0d_rdy", i), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check("strm_end_valid", 64'(out_valid), 64'd0);

        // Backpressure: three offered, two fit, then drain in order.
        out_ready = 1'b0;
        offer(6'h09, 5'd1, 16'h0001, 32'hA0);
        step();
        check("bp_a_pc", 64'(out_pc), 64'hA0);
        check("bp_a_rdy", 64'(in_ready), 64'd1);
        offer(6'h02, 5'd2, 16'h0002, 32'hA4);
        step();
        check("bp_b_rdy", 64'(in_ready), 64'd0);
        check("bp_b_hold_pc", 64'(out_pc), 64'hA0);
        offer(6'h0B, 5'd3, 16'h8003, 32'hA8);
        step();
        check("bp_c_hold_pc", 64'(out_pc), 64'hA0);
        check("bp_c_hold_imm", 64'(out_imm), 64'h1);
        check("bp_c_valid", 64'(out_valid), 64'd1);
        check("bp_c_rdy", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        check("bp_out2_pc", 64'(out_pc), 64'hA4);
        check("bp_out2_imm", 64'(out_imm), 64'd0);
        check("bp_out2_use", 64'(out_use_imm), 64'd0);
        check("bp_out2_rdy", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_out3_pc", 64'(out_pc), 64'hA8);
        check("bp_out3_imm", 64'(out_imm), 64'hFFFF_8003);
        step();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush with skid full and a word offered in the same cycle.
        out_ready = 1'b0;
        offer(6'h08, 5'd1, 16'h0011, 32'hB0);
        step();
        offer(6'h08, 5'd2, 16'h0022, 32'hB4);
        step();
        check("fl_full_rdy", 64'(in_ready), 64'd0);
        flush = 1'b1;
        offer(6'h08, 5'd3, 16'h0033, 32'hB8);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_rdy", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        check("fl_no_ghost", 64'(out_valid), 64'd0);

        // Async reset with two words held.
        out_ready = 1'b0;
        offer(6'h0D, 5'd4, 16'h0044, 32'hC0);
        step();
        offer(6'h0D, 5'd5, 16'h0055, 32'hC4);
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_imm", 64'(out_imm), 64'd0);
        check("ar_pc", 64'(out_pc), 64'd0);
        check("ar_rt", 64'(out_rt), 64'd0);
        check("ar_rdy", 64'(in_ready), 64'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("ar_rel_rdy", 64'(in_ready), 64'd1);
        offer(6'h0E, 5'd6, 16'hABCD, 32'hD0);
        step();
        in_valid = 1'b0;
        check("ar_new_pc", 64'(out_pc), 64'hD0);
        check("ar_new_imm", 64'(out_imm), 64'h0000_ABCD);
        step();
        check("ar_empty", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule
